// File: rtl/des_pkg.sv
// des_pkg: shared types and constants for the DES frame/round sequencer.
package des_pkg;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned DES_ROUNDS = 16;

  // Frame slot indices, in host transmission order.
  localparam logic [1:0] SLOT_KEY  = 2'd0;
  localparam logic [1:0] SLOT_DATA = 2'd1;
  localparam logic [1:0] SLOT_CTRL = 2'd2;
  localparam logic [1:0] SLOT_NONE = 2'd3;

  localparam int unsigned CTRL_DECRYPT_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GOT_KEY  = 3'd1,
    S_GOT_DATA = 3'd2,
    S_LOAD     = 3'd3,
    S_ROUND    = 3'd4,
    S_CAPTURE  = 3'd5
  } state_t;

  // Which frame slot the next accepted word fills; SLOT_NONE while busy.
  function automatic logic [1:0] slot_of(input state_t s);
    logic [1:0] slot;
    case (s)
      S_IDLE:     slot = SLOT_KEY;
      S_GOT_KEY:  slot = SLOT_DATA;
      S_GOT_DATA: slot = SLOT_CTRL;
      default:    slot = SLOT_NONE;
    endcase
    return slot;
  endfunction

endpackage

// File: rtl/des_round_counter.sv
// des_round_counter: round index for the iterative DES datapath. clr/adv are
// next-cycle requests, so en, idx and last are all registered.
module des_round_counter
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS = DES_ROUNDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS - 1);

  logic [IDX_W-1:0] idx_nxt_c;

  // Next index: clear on load, step on each active round, wrap after the last.
  always_comb begin
    idx_nxt_c = idx;
    if (clr) begin
      idx_nxt_c = '0;
    end else if (en) begin
      idx_nxt_c = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // Counter and round-enable registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      en   <= 1'b0;
      idx  <= '0;
      last <= 1'b0;
    end else begin
      en   <= adv;
      idx  <= idx_nxt_c;
      last <= adv && (idx_nxt_c == IDX_LAST);
    end
  end

endmodule

// File: rtl/des_seq_ctrl.sv
// des_seq_ctrl: collects a KEY/DATA/CONTROL frame from the SPI slave, runs
// the iterative DES datapath for ROUNDS rounds and captures the result.
// Optional: define DES_SEQ_FRAME_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYC consecutive idle cycles.
module des_seq_ctrl
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS = DES_ROUNDS
`ifdef DES_SEQ_FRAME_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [WORD_W-1:0] rx_data,
  output logic [WORD_W-1:0] key_out,
  output logic [WORD_W-1:0] blk_out,
  output logic              decrypt,
  output logic              round_load,
  output logic              round_en,
  output logic [IDX_W-1:0]  round_idx,
  output logic              round_last,
  input  logic [WORD_W-1:0] dp_result,
  output logic [WORD_W-1:0] tx_data,
  output logic              busy,
  output logic              done_encrypt_latched,
  output logic              done_decrypt_latched,
  output logic              err_overrun
);

  state_t state, state_nxt;

  logic timeout_c;
  logic key_ld_c, blk_ld_c, ctl_ld_c, cap_c, ovr_c;
  logic load_nxt_c, round_nxt_c, busy_nxt_c;

`ifdef DES_SEQ_FRAME_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              in_frame_c;

  assign in_frame_c = (state == S_GOT_KEY) || (state == S_GOT_DATA);
  assign timeout_c  = in_frame_c && !rx_valid &&
                      (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  // Idle cycles spent waiting inside a partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!in_frame_c || rx_valid || timeout_c) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: frame collection, then a fixed load/round/capture run.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (rx_valid) state_nxt = S_GOT_KEY;
      S_GOT_KEY:  if (rx_valid) state_nxt = S_GOT_DATA;
                  else if (timeout_c) state_nxt = S_IDLE;
      S_GOT_DATA: if (rx_valid) state_nxt = S_LOAD;
                  else if (timeout_c) state_nxt = S_IDLE;
      S_LOAD:     state_nxt = S_ROUND;
      S_ROUND:    if (round_last) state_nxt = S_CAPTURE;
      S_CAPTURE:  state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output decode: word routing, overrun, capture and next-cycle strobes.
  always_comb begin
    key_ld_c    = 1'b0;
    blk_ld_c    = 1'b0;
    ctl_ld_c    = 1'b0;
    ovr_c       = 1'b0;
    cap_c       = (state == S_CAPTURE);
    load_nxt_c  = (state_nxt == S_LOAD);
    round_nxt_c = (state_nxt == S_ROUND);
    busy_nxt_c  = (state_nxt == S_LOAD) || (state_nxt == S_ROUND) ||
                  (state_nxt == S_CAPTURE);
    if (rx_valid) begin
      case (slot_of(state))
        SLOT_KEY:  key_ld_c = 1'b1;
        SLOT_DATA: blk_ld_c = 1'b1;
        SLOT_CTRL: ctl_ld_c = 1'b1;
        default:   ovr_c    = 1'b1;
      endcase
    end
  end

  // Frame, result and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_out              <= '0;
      blk_out              <= '0;
      decrypt              <= 1'b0;
      round_load           <= 1'b0;
      busy                 <= 1'b0;
      tx_data              <= '0;
      done_encrypt_latched <= 1'b0;
      done_decrypt_latched <= 1'b0;
      err_overrun          <= 1'b0;
    end else begin
      round_load  <= load_nxt_c;
      busy        <= busy_nxt_c;
      err_overrun <= ovr_c;
      if (key_ld_c) begin
        key_out              <= rx_data;
        done_encrypt_latched <= 1'b0;
        done_decrypt_latched <= 1'b0;
      end
      if (blk_ld_c) begin
        blk_out <= rx_data;
      end
      if (ctl_ld_c) begin
        decrypt <= rx_data[CTRL_DECRYPT_BIT];
      end
      if (cap_c) begin
        tx_data <= dp_result;
        if (decrypt) begin
          done_decrypt_latched <= 1'b1;
        end else begin
          done_encrypt_latched <= 1'b1;
        end
      end
    end
  end

  des_round_counter #(
    .ROUNDS (ROUNDS)
  ) u_round_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_nxt_c),
    .adv  (round_nxt_c),
    .en   (round_en),
    .idx  (round_idx),
    .last (round_last)
  );

endmodule
